// File: rtl/ms_clk_sel_ctrl.sv
// Clock-source switch sequencer: parks on 8 MHz, retargets the source mux, then engages
// the new source and divider; also supervises xclk and falls back to 8 MHz when it stops.
module ms_clk_sel_ctrl #(
    parameter int SETTLE_CYC   = 16,
    parameter int XMON_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [1:0] req_src_i,
    input  logic [1:0] req_rosc_i,
    input  logic [1:0] req_div_i,
    input  logic       xclk_tgl_i,
    output logic       sel_n_8mhz_o,
    output logic       sel_xclk_o,
    output logic [1:0] sel_rosc_o,
    output logic [1:0] clk_div_o,
    output logic [1:0] cur_src_o,
    output logic       busy_o,
    output logic       xclk_fail_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PARK,
        ST_SETUP,
        ST_ENGAGE,
        ST_DIV
    } state_t;

    localparam logic [7:0] DWELL_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [9:0] GAP_LAST   = 10'(XMON_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       tgl_s1_q, tgl_s2_q, tgl_s3_q;
    logic [9:0] gap_q, gap_d;
    logic [7:0] dwell_q, dwell_d;
    logic       edge_seen_q, edge_seen_d;
    logic [1:0] src_q, src_d;
    logic [1:0] rosc_q, rosc_d;
    logic [1:0] div_q, div_d;
    logic       sel_n_8mhz_q, sel_n_8mhz_d;
    logic       sel_xclk_q, sel_xclk_d;
    logic [1:0] sel_rosc_q, sel_rosc_d;
    logic [1:0] clk_div_q, clk_div_d;
    logic [1:0] cur_src_q, cur_src_d;
    logic       xclk_fail_q, xclk_fail_d;

    logic tgl_edge;
    logic gap_to;
    logic xclk_lost;

    assign tgl_edge  = tgl_s2_q ^ tgl_s3_q;
    assign gap_to    = (gap_q == GAP_LAST) && !tgl_edge;
    assign xclk_lost = (cur_src_q == 2'd1) && gap_to;

    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        edge_seen_d  = edge_seen_q;
        src_d        = src_q;
        rosc_d       = rosc_q;
        div_d        = div_q;
        sel_n_8mhz_d = sel_n_8mhz_q;
        sel_xclk_d   = sel_xclk_q;
        sel_rosc_d   = sel_rosc_q;
        clk_div_d    = clk_div_q;
        cur_src_d    = cur_src_q;
        xclk_fail_d  = xclk_fail_q;
        req_ready_o  = 1'b0;

        // Gap counter saturates so gap_to stays asserted until xclk toggles again.
        if (tgl_edge) begin
            gap_d = '0;
        end else if (gap_q != GAP_LAST) begin
            gap_d = gap_q + 10'd1;
        end else begin
            gap_d = gap_q;
        end

        case (state_q)
            ST_IDLE: begin
                req_ready_o = !xclk_lost;
                if (xclk_lost) begin
                    sel_n_8mhz_d = 1'b0;
                    sel_xclk_d   = 1'b0;
                    clk_div_d    = 2'd0;
                    cur_src_d    = 2'd0;
                    xclk_fail_d  = 1'b1;
                end else if (req_valid_i) begin
                    src_d        = (req_src_i == 2'd3) ? 2'd0 : req_src_i;
                    rosc_d       = req_rosc_i;
                    div_d        = req_div_i;
                    xclk_fail_d  = 1'b0;
                    dwell_d      = '0;
                    sel_n_8mhz_d = 1'b0;
                    state_d      = ST_PARK;
                end
            end
            ST_PARK: begin
                if (dwell_q == DWELL_LAST) begin
                    sel_xclk_d  = (src_q == 2'd1);
                    sel_rosc_d  = (src_q == 2'd2) ? rosc_q : 2'd0;
                    cur_src_d   = 2'd0;
                    dwell_d     = '0;
                    gap_d       = '0;
                    edge_seen_d = 1'b0;
                    state_d     = ST_SETUP;
                end else begin
                    dwell_d = dwell_q + 8'd1;
                end
            end
            ST_SETUP: begin
                if (tgl_edge) begin
                    edge_seen_d = 1'b1;
                end
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + 8'd1;
                end
                // An xclk target must also have shown life before it is engaged.
                if ((dwell_q == DWELL_LAST) &&
                    ((src_q != 2'd1) || edge_seen_q || tgl_edge)) begin
                    state_d = ST_ENGAGE;
                end else if ((src_q == 2'd1) && gap_to) begin
                    xclk_fail_d = 1'b1;
                    sel_xclk_d  = 1'b0;
                    cur_src_d   = 2'd0;
                    state_d     = ST_IDLE;
                end
            end
            ST_ENGAGE: begin
                sel_n_8mhz_d = (src_q != 2'd0);
                cur_src_d    = src_q;
                state_d      = ST_DIV;
            end
            ST_DIV: begin
                clk_div_d = div_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            tgl_s1_q     <= 1'b0;
            tgl_s2_q     <= 1'b0;
            tgl_s3_q     <= 1'b0;
            gap_q        <= '0;
            dwell_q      <= '0;
            edge_seen_q  <= 1'b0;
            src_q        <= 2'd0;
            rosc_q       <= 2'd0;
            div_q        <= 2'd0;
            sel_n_8mhz_q <= 1'b0;
            sel_xclk_q   <= 1'b0;
            sel_rosc_q   <= 2'd0;
            clk_div_q    <= 2'd0;
            cur_src_q    <= 2'd0;
            xclk_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tgl_s1_q     <= xclk_tgl_i;
            tgl_s2_q     <= tgl_s1_q;
            tgl_s3_q     <= tgl_s2_q;
            gap_q        <= gap_d;
            dwell_q      <= dwell_d;
            edge_seen_q  <= edge_seen_d;
            src_q        <= src_d;
            rosc_q       <= rosc_d;
            div_q        <= div_d;
            sel_n_8mhz_q <= sel_n_8mhz_d;
            sel_xclk_q   <= sel_xclk_d;
            sel_rosc_q   <= sel_rosc_d;
            clk_div_q    <= clk_div_d;
            cur_src_q    <= cur_src_d;
            xclk_fail_q  <= xclk_fail_d;
        end
    end

    assign sel_n_8mhz_o = sel_n_8mhz_q;
    assign sel_xclk_o   = sel_xclk_q;
    assign sel_rosc_o   = sel_rosc_q;
    assign clk_div_o    = clk_div_q;
    assign cur_src_o    = cur_src_q;
    assign xclk_fail_o  = xclk_fail_q;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ms_clk_sel_ctrl.sv
// Bench for ms_clk_sel_ctrl: constant-vector table, directed corner sequences, and random
// traffic checked every cycle against a timestamp-based model of the switch rules.
module tb_ms_clk_sel_ctrl;

    localparam int S = 16;
    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       valid = 1'b0;
    logic [1:0] src = 2'd0;
    logic [1:0] rosc = 2'd0;
    logic [1:0] div = 2'd0;
    logic       tgl = 1'b0;

    logic       reqReady, selN8, selXclk, busy, xclkFail;
    logic [1:0] selRosc, clkDiv, curSrc;

    ms_clk_sel_ctrl #(.SETTLE_CYC(S), .XMON_TIMEOUT(T)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (valid),
        .req_ready_o  (reqReady),
        .req_src_i    (src),
        .req_rosc_i   (rosc),
        .req_div_i    (div),
        .xclk_tgl_i   (tgl),
        .sel_n_8mhz_o (selN8),
        .sel_xclk_o   (selXclk),
        .sel_rosc_o   (selRosc),
        .clk_div_o    (clkDiv),
        .cur_src_o    (curSrc),
        .busy_o       (busy),
        .xclk_fail_o  (xclkFail)
    );

    always #5 clk = ~clk;

    int nVec = 0;
    int nMis = 0;
    int cyc = 0;
    int lastChg = 0;
    int tglPeriod = 0;
    int accCount = 0;

    logic hist [0:65535];
    int   rstEdge = 0;
    int   lastClear = 0;

    // Model state: outputs plus timestamps of the accept edge (mA) and the go-to-engage edge (mG).
    logic       mSelN = 1'b0, mSelX = 1'b0, mBusy = 1'b0, mFail = 1'b0, mSaw = 1'b0;
    logic [1:0] mRosc = 2'd0, mDiv = 2'd0, mCur = 2'd0;
    logic [1:0] mSrc = 2'd0, mRoscReq = 2'd0, mDivReq = 2'd0;
    int         mA = 0, mG = -1;

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic [1:0] r;
        logic [1:0] d;
        int         n;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic tv(input int k);
        if (k <= rstEdge) return 1'b0;
        return hist[k];
    endfunction

    function automatic logic edgeAt(input int t);
        return tv(t - 2) != tv(t - 3);
    endfunction

    task automatic modelEdge(input int t, input logic v, input logic [1:0] s,
                             input logic [1:0] r, input logic [1:0] d, input logic rs);
        logic e, gto, clr;
        int   rel;
        if (rs) begin
            {mSelN, mSelX, mBusy, mFail, mSaw} = '0;
            {mRosc, mDiv, mCur} = '0;
            mG = -1;
            rstEdge = t;
            lastClear = t;
            return;
        end
        e   = edgeAt(t);
        gto = ((t - lastClear) >= T) && !e;
        clr = e;
        if (!mBusy) begin
            if (mCur == 2'd1 && gto) begin
                mSelN = 1'b0; mSelX = 1'b0; mDiv = 2'd0; mCur = 2'd0; mFail = 1'b1;
            end else if (v) begin
                mSrc = (s == 2'd3) ? 2'd0 : s;
                mRoscReq = r; mDivReq = d;
                mFail = 1'b0; mSelN = 1'b0;
                mA = t; mG = -1; mSaw = 1'b0; mBusy = 1'b1;
            end
        end else begin
            rel = t - mA;
            if (mG >= 0 && t == mG + 1) begin
                mSelN = (mSrc != 2'd0);
                mCur = mSrc;
            end else if (mG >= 0 && t == mG + 2) begin
                mDiv = mDivReq;
                mBusy = 1'b0;
            end else if (rel == S) begin
                mSelX = (mSrc == 2'd1);
                mRosc = (mSrc == 2'd2) ? mRoscReq : 2'd0;
                mCur = 2'd0;
                clr = 1'b1;
            end else if (rel > S) begin
                if (rel >= 2 * S && (mSrc != 2'd1 || mSaw || e)) begin
                    mG = t;
                end else if (mSrc == 2'd1 && gto) begin
                    mFail = 1'b1; mSelX = 1'b0; mCur = 2'd0; mBusy = 1'b0;
                end else if (e) begin
                    mSaw = 1'b1;
                end
            end
        end
        if (clr) lastClear = t;
    endtask

    function automatic logic [10:0] modelVec();
        logic gtoNext, rdy;
        gtoNext = ((cyc + 1 - lastClear) >= T) && (tv(cyc - 1) == tv(cyc - 2));
        rdy = !mBusy && !(mCur == 2'd1 && gtoNext);
        return {mSelN, mSelX, mRosc, mDiv, mCur, mBusy, mFail, rdy};
    endfunction

    task automatic checkOutput(input string name, input logic [10:0] exp);
        logic [10:0] got;
        got = {selN8, selXclk, selRosc, clkDiv, curSrc, busy, xclkFail, reqReady};
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("[TB] FAIL %s at cycle %0d: got selN/selX/rosc/div/cur/busy/fail/rdy=%b, expected %b",
                     name, cyc, got, exp);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        nVec++;
        if (got != exp) begin
            nMis++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [1:0] r,
                                 input logic [1:0] d, input logic rs);
        if (tglPeriod != 0 && (cyc % tglPeriod) == 0) begin
            tgl = ~tgl;
            lastChg = cyc;
        end
        rst = rs; valid = v; src = s; rosc = r; div = d;
        if (!rs && v && reqReady) accCount++;
        @(posedge clk);
        cyc++;
        hist[cyc] = tgl;
        modelEdge(cyc, v, s, r, d, rs);
        #1;
        checkOutput("model", modelVec());
    endtask

    task automatic stepIdle();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
    endtask

    task automatic waitIdle(input string name, input int limit);
        int n = 0;
        while (busy && n < limit) begin
            stepIdle();
            n++;
        end
        if (busy) begin
            nVec++;
            nMis++;
            $display("[TB] FAIL %s: still busy after %0d cycles, expected idle", name, limit);
        end
    endtask

    initial begin
        int a, n, f;
        hist[0] = 1'b0;

        // {selN, selX, rosc, div, cur, busy, fail, ready} after each row's last cycle.
        vecs[0]  = '{1'b1, 2'd2, 2'd3, 2'd1, 1,  {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{1'b0, 2'd0, 2'd0, 2'd0, 15, {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0}};
        vecs[2]  = '{1'b0, 2'd0, 2'd0, 2'd0, 1,  {1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0}};
        vecs[3]  = '{1'b0, 2'd0, 2'd0, 2'd0, 16, {1'b0, 1'b0, 2'd3, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0}};
        vecs[4]  = '{1'b0, 2'd0, 2'd0, 2'd0, 1,  {1'b1, 1'b0, 2'd3, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0}};
        vecs[5]  = '{1'b0, 2'd0, 2'd0, 2'd0, 1,  {1'b1, 1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1}};
        vecs[6]  = '{1'b0, 2'd0, 2'd0, 2'd0, 3,  {1'b1, 1'b0, 2'd3, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1}};
        vecs[7]  = '{1'b1, 2'd3, 2'd2, 2'd2, 1,  {1'b0, 1'b0, 2'd3, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0}};
        vecs[8]  = '{1'b1, 2'd1, 2'd1, 2'd3, 15, {1'b0, 1'b0, 2'd3, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{1'b0, 2'd0, 2'd0, 2'd0, 1,  {1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0}};
        vecs[10] = '{1'b0, 2'd0, 2'd0, 2'd0, 17, {1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0}};
        vecs[11] = '{1'b0, 2'd0, 2'd0, 2'd0, 1,  {1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b1}};

        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        checkOutput("reset", 11'b000_0000_0001);
        stepIdle();
        checkOutput("ready after reset", 11'b000_0000_0001);

        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                applyStimulus(vecs[i].v, vecs[i].s, vecs[i].r, vecs[i].d, 1'b0);
            end
            checkOutput($sformatf("table row %0d", i), vecs[i].exp);
        end

        // Switch onto a live xclk.
        tglPeriod = 8;
        repeat (30) stepIdle();
        applyStimulus(1'b1, 2'd1, 2'd2, 2'd2, 1'b0);
        waitIdle("xclk switch", 200);
        checkOutput("on xclk", {1'b1, 1'b1, 2'd0, 2'd2, 2'd1, 1'b0, 1'b0, 1'b1});

        // Stop xclk: fallback lands exactly T cycles after the last detected edge.
        tglPeriod = 0;
        n = 0;
        while (!xclkFail && n < 200) begin
            stepIdle();
            n++;
        end
        checkValue("fallback cycle", cyc, lastChg + 3 + T);
        checkOutput("after fallback", {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1});
        applyStimulus(1'b1, 2'd0, 2'd0, 2'd3, 1'b0);
        checkOutput("fail cleared on accept", {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0});
        waitIdle("8mhz switch", 200);
        checkOutput("on 8mhz div3", {1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b1});

        // Static xclk: request aborts in SETUP, divider untouched.
        applyStimulus(1'b1, 2'd1, 2'd2, 2'd1, 1'b0);
        a = cyc;
        waitIdle("xclk abort", 300);
        checkValue("abort latency", cyc - a, S + T);
        checkOutput("after abort", {1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b1});

        // Reset in the middle of SETUP, then a request held high across the busy period.
        applyStimulus(1'b1, 2'd2, 2'd1, 2'd2, 1'b0);
        repeat (19) stepIdle();
        applyStimulus(1'b0, 2'd0, 2'd0, 2'd0, 1'b1);
        checkOutput("mid-setup reset", 11'b000_0000_0001);
        accCount = 0;
        applyStimulus(1'b1, 2'd2, 2'd1, 2'd2, 1'b0);
        n = 0;
        while (busy && n < 100) begin
            applyStimulus(1'b1, 2'd2, 2'd1, 2'd2, 1'b0);
            n++;
        end
        checkValue("held-valid accepts", accCount, 1);
        checkOutput("on rosc1 div2", {1'b1, 1'b0, 2'd1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b1});

        // Fallback and request land on the same IDLE edge: fallback wins, request retried.
        tglPeriod = 8;
        repeat (20) stepIdle();
        applyStimulus(1'b1, 2'd1, 2'd0, 2'd1, 1'b0);
        waitIdle("xclk switch 2", 200);
        checkOutput("on xclk div1", {1'b1, 1'b1, 2'd0, 2'd1, 2'd1, 1'b0, 1'b0, 1'b1});
        tglPeriod = 0;
        f = lastChg + 3 + T;
        while (cyc < f - 1) stepIdle();
        applyStimulus(1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        checkOutput("fallback beats request", {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1});
        applyStimulus(1'b1, 2'd0, 2'd0, 2'd1, 1'b0);
        checkOutput("request next cycle", {1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0});
        waitIdle("retry switch", 200);

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    tglPeriod = 0;
                    2:       tglPeriod = 3;
                    3:       tglPeriod = 8;
                    4:       tglPeriod = 20;
                    default: tglPeriod = 50;
                endcase
            end
            applyStimulus(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          ($urandom_range(0, 599) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
